// File: rtl/stream_demux_n_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer.
package stream_demux_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

    function automatic logic sel_in_range(input logic [31:0] sel, input int unsigned n_out);
        return sel < n_out;
    endfunction

endpackage

// File: rtl/stream_demux_n_if.sv
// Producer-side and consumer-side handshake bundle of the stream demultiplexer.
interface stream_demux_n_if #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = 2
);
    logic [DATA_W-1:0]       s_data;
    logic [SEL_W-1:0]        s_sel;
    logic                    s_last;
    logic                    s_valid;
    logic                    s_ready;
    logic [N_OUT*DATA_W-1:0] m_data;
    logic [N_OUT-1:0]        m_last;
    logic [N_OUT-1:0]        m_valid;
    logic [N_OUT-1:0]        m_ready;

    // A beat moves on a rising edge where valid and ready are both high; a raised
    // valid holds its payload until taken, and s_ready never looks at s_valid.
    modport master (
        output s_data, s_sel, s_last, s_valid, m_ready,
        input  s_ready, m_data, m_last, m_valid
    );

    modport slave (
        input  s_data, s_sel, s_last, s_valid, m_ready,
        output s_ready, m_data, m_last, m_valid
    );
endinterface

// File: rtl/stream_demux_n_slot.sv
// One-entry output register slice for a single demux channel.
module demux_out_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              free,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready
);
    // A full slot that is draining this cycle can be refilled in the same cycle.
    assign free = !m_valid || m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  <= '0;
            m_last  <= 1'b0;
            m_valid <= 1'b0;
        end else if (wr_en) begin
            m_data  <= wr_data;
            m_last  <= wr_last;
            m_valid <= 1'b1;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/stream_demux_n.sv
// 1-to-N stream demultiplexer with registered per-channel slots, packet-locked
// routing and a saturating count of beats discarded for an out-of-range select.
module stream_demux_n
    import stream_demux_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int N_OUT    = 4,
    parameter int SEL_W    = 2,
    parameter int PKT_MODE = 1,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    stream_demux_n_if.slave     bus,
    output logic                in_pkt,
    output logic [CNT_W-1:0]    drop_cnt,
    output state_t              dbg_state
);
    state_t             state;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   route;
    logic               route_ok;
    logic               rdy;
    logic               accept;
    logic [N_OUT-1:0]   slot_free;
    logic [N_OUT-1:0]   wr_en;

    assign dbg_state = state;

    always_comb begin
        route = bus.s_sel;
        if (PKT_MODE != 0 && state == ST_IN_PKT) route = sel_q;
    end

    assign route_ok = sel_in_range(32'(route), N_OUT);

    // An out-of-range route matches no channel, so rdy stays 1 and the beat is swallowed.
    always_comb begin
        rdy   = 1'b1;
        wr_en = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (route == SEL_W'(k)) begin
                rdy      = slot_free[k];
                wr_en[k] = bus.s_valid && slot_free[k];
            end
        end
    end

    assign bus.s_ready = rdy;
    assign accept      = bus.s_valid && rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sel_q    <= '0;
            in_pkt   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (accept && !route_ok && drop_cnt != {CNT_W{1'b1}}) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
            if (PKT_MODE != 0 && accept) begin
                case (state)
                    ST_IDLE: begin
                        if (!bus.s_last) begin
                            state  <= ST_IN_PKT;
                            sel_q  <= bus.s_sel;
                            in_pkt <= 1'b1;
                        end
                    end
                    ST_IN_PKT: begin
                        if (bus.s_last) begin
                            state  <= ST_IDLE;
                            in_pkt <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        in_pkt <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_out_slot #(.DATA_W(DATA_W)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en[k]),
            .wr_data (bus.s_data),
            .wr_last (bus.s_last),
            .free    (slot_free[k]),
            .m_data  (bus.m_data[k*DATA_W +: DATA_W]),
            .m_last  (bus.m_last[k]),
            .m_valid (bus.m_valid[k]),
            .m_ready (bus.m_ready[k])
        );
    end
endmodule

// File: tb/tb_stream_demux_n.sv
// Drives three demux configurations from one stimulus stream and checks them
// against a per-channel queue model of the routing rules.
module tb_stream_demux_n;
    import stream_demux_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = '0;
    logic [1:0] s_sel = '0;
    logic       s_last = 1'b0;
    logic       s_valid = 1'b0;
    logic [3:0] m_ready = 4'hF;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // a: 4 channels, packet mode; b: 3 channels, packet mode; c: 3 channels, per-beat, 2-bit counter
    stream_demux_n_if #(.DATA_W(8), .N_OUT(4), .SEL_W(2)) a_if ();
    stream_demux_n_if #(.DATA_W(8), .N_OUT(3), .SEL_W(2)) b_if ();
    stream_demux_n_if #(.DATA_W(8), .N_OUT(3), .SEL_W(2)) c_if ();

    logic        ip_a, ip_b, ip_c;
    logic [15:0] dc_a, dc_b;
    logic [1:0]  dc_c;
    state_t      st_a, st_b, st_c;

    stream_demux_n #(.DATA_W(8), .N_OUT(4), .SEL_W(2), .PKT_MODE(1), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if.slave), .in_pkt(ip_a), .drop_cnt(dc_a), .dbg_state(st_a));
    stream_demux_n #(.DATA_W(8), .N_OUT(3), .SEL_W(2), .PKT_MODE(1), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if.slave), .in_pkt(ip_b), .drop_cnt(dc_b), .dbg_state(st_b));
    stream_demux_n #(.DATA_W(8), .N_OUT(3), .SEL_W(2), .PKT_MODE(0), .CNT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(c_if.slave), .in_pkt(ip_c), .drop_cnt(dc_c), .dbg_state(st_c));

    assign a_if.s_data = s_data;  assign a_if.s_sel = s_sel;  assign a_if.s_last = s_last;
    assign a_if.s_valid = s_valid; assign a_if.m_ready = m_ready;
    assign b_if.s_data = s_data;  assign b_if.s_sel = s_sel;  assign b_if.s_last = s_last;
    assign b_if.s_valid = s_valid; assign b_if.m_ready = m_ready[2:0];
    assign c_if.s_data = s_data;  assign c_if.s_sel = s_sel;  assign c_if.s_last = s_last;
    assign c_if.s_valid = s_valid; assign c_if.m_ready = m_ready[2:0];

    // Uniform views of the three DUTs, zero-extended to four channels.
    logic [3:0]  mv[3];
    logic [3:0]  ml[3];
    logic [31:0] md[3];
    logic        sr[3];
    logic        ip[3];
    logic [15:0] dc[3];

    assign mv[0] = a_if.m_valid;          assign mv[1] = {1'b0, b_if.m_valid};  assign mv[2] = {1'b0, c_if.m_valid};
    assign ml[0] = a_if.m_last;           assign ml[1] = {1'b0, b_if.m_last};   assign ml[2] = {1'b0, c_if.m_last};
    assign md[0] = a_if.m_data;           assign md[1] = {8'h0, b_if.m_data};   assign md[2] = {8'h0, c_if.m_data};
    assign sr[0] = a_if.s_ready;          assign sr[1] = b_if.s_ready;          assign sr[2] = c_if.s_ready;
    assign ip[0] = ip_a;                  assign ip[1] = ip_b;                  assign ip[2] = ip_c;
    assign dc[0] = dc_a;                  assign dc[1] = dc_b;                  assign dc[2] = {14'h0, dc_c};

    // Reference model: what each channel still owes its consumer, in order.
    int          n_out_m[3] = '{4, 3, 3};
    bit          mode_m[3]  = '{1'b1, 1'b1, 1'b0};
    int          cmax_m[3]  = '{65535, 65535, 3};
    logic [8:0]  exp_q[12][$];
    bit          locked[3];
    int          lroute[3];
    int          drop_m[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_cycle(input int d);
        int  n;
        int  route;
        int  qi;
        bit  er;
        n = n_out_m[d];
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) exp_q[d*4+k].delete();
            locked[d] = 1'b0;
            drop_m[d] = 0;
            chk($sformatf("rst_m_valid[%0d]", d), 32'(mv[d]), 32'h0);
            chk($sformatf("rst_in_pkt[%0d]", d), 32'(ip[d]), 32'h0);
            chk($sformatf("rst_drop_cnt[%0d]", d), 32'(dc[d]), 32'h0);
            return;
        end
        for (int k = 0; k < n; k++) begin
            qi = d*4 + k;
            chk($sformatf("m_valid[%0d][%0d]", d, k), 32'(mv[d][k]), 32'(exp_q[qi].size() != 0));
            if (exp_q[qi].size() != 0) begin
                chk($sformatf("m_data[%0d][%0d]", d, k), 32'(md[d][k*8 +: 8]), 32'(exp_q[qi][0][7:0]));
                chk($sformatf("m_last[%0d][%0d]", d, k), 32'(ml[d][k]), 32'(exp_q[qi][0][8]));
            end
        end
        route = (mode_m[d] && locked[d]) ? lroute[d] : int'(s_sel);
        if (route >= n) er = 1'b1;
        else            er = (exp_q[d*4+route].size() == 0) || m_ready[route];
        chk($sformatf("s_ready[%0d]", d), 32'(sr[d]), 32'(er));
        chk($sformatf("in_pkt[%0d]", d), 32'(ip[d]), 32'(locked[d]));
        chk($sformatf("drop_cnt[%0d]", d), 32'(dc[d]), 32'(drop_m[d]));
        for (int k = 0; k < n; k++) begin
            if (exp_q[d*4+k].size() != 0 && m_ready[k]) void'(exp_q[d*4+k].pop_front());
        end
        if (s_valid && er) begin
            if (route < n) exp_q[d*4+route].push_back({s_last, s_data});
            else if (drop_m[d] < cmax_m[d]) drop_m[d]++;
            if (mode_m[d]) begin
                if (!locked[d] && !s_last) begin
                    locked[d] = 1'b1;
                    lroute[d] = int'(s_sel);
                end else if (locked[d] && s_last) begin
                    locked[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 3; d++) model_cycle(d);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [7:0] data, input logic last);
        s_valid = 1'b1;
        s_sel   = sel;
        s_data  = data;
        s_last  = last;
    endtask

    task automatic idle();
        s_valid = 1'b0;
    endtask

    initial begin
        // reset
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // single beats to every select, all consumers ready
        for (int k = 0; k < 4; k++) begin
            drive(2'(k), 8'hA0 + 8'(k), 1'b1);
            #1 chk("t1_s_ready", 32'(sr[0]), 32'h1);
            step();
            chk("t1_m_valid", 32'(mv[0][k]), 32'h1);
            chk("t1_m_data", 32'(md[0][k*8 +: 8]), 32'(8'hA0 + 8'(k)));
        end
        idle();
        step();

        // 3-beat packet locked to ch2 while s_sel wanders to 1
        drive(2'd2, 8'hD0, 1'b0);
        step();
        chk("t2_in_pkt", 32'(ip[0]), 32'h1);
        drive(2'd1, 8'hD1, 1'b0);
        step();
        chk("t2_beat2_ch2", 32'(md[0][23:16]), 32'hD1);
        drive(2'd1, 8'hD2, 1'b1);
        step();
        chk("t2_last_ch2", 32'(ml[0][2]), 32'h1);
        chk("t2_ch1_quiet", 32'(mv[0][1]), 32'h0);
        chk("t2_in_pkt_end", 32'(ip[0]), 32'h0);
        idle();
        step();

        // ch1 stalled: second beat waits, ch0 keeps flowing
        m_ready = 4'b1101;
        drive(2'd1, 8'hB0, 1'b1);
        step();
        drive(2'd1, 8'hB1, 1'b1);
        #1 chk("t3_s_ready_stall", 32'(sr[0]), 32'h0);
        step();
        drive(2'd0, 8'hC0, 1'b1);
        step();
        chk("t3_ch0_flows", 32'(md[0][7:0]), 32'hC0);
        chk("t3_ch1_held", 32'(md[0][15:8]), 32'hB0);
        drive(2'd1, 8'hB1, 1'b1);
        m_ready = 4'hF;
        #1 chk("t3_s_ready_drain", 32'(sr[0]), 32'h1);
        step();
        chk("t3_ch1_second", 32'(md[0][15:8]), 32'hB1);
        idle();
        step();

        // 4-beat packet at sel 3: valid on a, discarded on the 3-channel parts
        for (int i = 0; i < 4; i++) begin
            drive(2'd3, 8'hE0 + 8'(i), 1'(i == 3));
            #1 chk("t4_s_ready", 32'(sr[1]), 32'h1);
            step();
            chk("t4_no_valid", 32'(mv[1]), 32'h0);
        end
        idle();
        step();
        chk("t4_drop_b", 32'(dc[1]), 32'd5);
        chk("t4_drop_c_sat", 32'(dc[2]), 32'd3);

        // async reset mid-packet with slots full
        m_ready = 4'h0;
        drive(2'd0, 8'h10, 1'b1); step();
        drive(2'd1, 8'h11, 1'b1); step();
        drive(2'd2, 8'h12, 1'b0); step();
        chk("t6_in_pkt_before", 32'(ip[0]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("t6_async_valid[%0d]", d), 32'(mv[d]), 32'h0);
            chk($sformatf("t6_async_in_pkt[%0d]", d), 32'(ip[d]), 32'h0);
        end
        idle();
        step();
        rst_n = 1'b1;
        m_ready = 4'hF;
        drive(2'd1, 8'h21, 1'b1);
        step();
        chk("t6_new_route", 32'(md[0][15:8]), 32'h21);
        chk("t6_old_route_quiet", 32'(mv[0][2]), 32'h0);

        // saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            drive(2'd3, 8'(i), 1'b1);
            step();
            chk("t5_drop_c", 32'(dc[2]), 32'((i + 1 > 3) ? 3 : i + 1));
            chk("t5_drop_b", 32'(dc[1]), 32'(i + 1));
        end
        idle();
        step();

        // randomized traffic with random backpressure
        for (int i = 0; i < 800; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_sel   = 2'($urandom_range(0, 3));
            s_data  = 8'($urandom);
            s_last  = ($urandom_range(0, 2) == 0);
            m_ready = 4'($urandom_range(0, 15));
            step();
        end
        idle();
        m_ready = 4'hF;
        repeat (3) step();
        for (int q = 0; q < 12; q++) chk($sformatf("drained[%0d]", q), 32'(exp_q[q].size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
